// File: rtl/logic_unit_pipe_if.sv
// Request/result handshake bundle for the logical-unit pipeline.
// The upstream side is in_*; the downstream side is out_*.
interface logic_unit_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_zero;
   logic             out_neg;
   logic             out_err;

   modport master (
      output in_valid, in_op, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_result,
      input  out_zero, out_neg, out_err
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, out_ready,
      output in_ready, out_valid, out_result,
      output out_zero, out_neg, out_err
   );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage logical unit: operand register, then result register with
// zero/neg/err flags, under valid/ready handshakes on both sides.
module logic_unit_pipe #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   logic_unit_pipe_if.slave bus,
   output logic [CNT_W-1:0] done_cnt
);
   typedef struct packed {
      logic [2:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } s1_t;

   logic             s1_valid;
   s1_t              s1;
   logic             out_valid;
   logic [WIDTH-1:0] out_result;
   logic             out_zero;
   logic             out_neg;
   logic             out_err;
   logic             s2_adv;
   logic             in_ready;
   logic [WIDTH-1:0] f_res;
   logic             f_err;

   assign s2_adv   = !out_valid || bus.out_ready;
   assign in_ready = !s1_valid || s2_adv;

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid;
   assign bus.out_result = out_result;
   assign bus.out_zero   = out_zero;
   assign bus.out_neg    = out_neg;
   assign bus.out_err    = out_err;

   // Opcode 111 falls through to the default: zero result, err raised.
   always_comb begin
      f_res = '0;
      f_err = 1'b0;
      unique case (1'b1)
         (s1.op == 3'b000): f_res = s1.a & s1.b;
         (s1.op == 3'b001): f_res = s1.a | s1.b;
         (s1.op == 3'b010): f_res = s1.a ^ s1.b;
         (s1.op == 3'b011): f_res = ~(s1.a | s1.b);
         (s1.op == 3'b100): f_res = ~(s1.a & s1.b);
         (s1.op == 3'b101): f_res = ~(s1.a ^ s1.b);
         (s1.op == 3'b110): f_res = ~s1.a;
         default:           f_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1       <= '0;
      end else if (bus.in_valid && in_ready) begin
         s1_valid <= 1'b1;
         s1       <= '{op: bus.in_op, a: bus.in_a, b: bus.in_b};
      end else if (s2_adv) begin
         s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_result <= '0;
         out_zero   <= 1'b0;
         out_neg    <= 1'b0;
         out_err    <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_result <= f_res;
            out_zero   <= (f_res == '0);
            out_neg    <= f_res[WIDTH-1];
            out_err    <= f_err;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_cnt <= '0;
      end else if (out_valid && bus.out_ready) begin
         done_cnt <= done_cnt + CNT_W'(1);
      end
   end
endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Two-stage pipelined front end for the ALU logical unit. It accepts operand pairs and a logical opcode over a valid/ready handshake, registers them, and evaluates the selected 32-bit bitwise operation. The result is held in an output register with zero, negative and error flags, under full downstream backpressure. It sits between the ALU operand/decode stage and the ALU result mux, and reuses the per-bit logic cells of the logical unit.

Parameters:
WIDTH, 32, operand and result width in bits (≥2).
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream presents a request
in_ready  output  1  block accepts request this cycle
in_op  input  3  opcode
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
out_valid  output  1  result register holds a valid result
out_ready  input  1  downstream accepts result this cycle
out_result  output  WIDTH  operation result
out_zero  output  1  out_result == 0
out_neg  output  1  out_result[WIDTH-1]
out_err  output  1  opcode was illegal
done_cnt  output  CNT_W  count of results handed off

Behaviour:
- Reset is asynchronous and active-low: rst_n low immediately clears s1_valid, out_valid, out_result, out_zero, out_neg, out_err and done_cnt to 0. in_ready is therefore 1 during and after reset. Stage-1 data registers are don't-care.
- Reset mid-operation drops all in-flight requests. No partial result is emitted.
- Opcodes:
  - 000 AND, 001 OR, 010 XOR, 011 NOR, 100 NAND, 101 XNOR.
  - 110 NOT A: result is ~in_a; in_b is ignored.
  - 111 is illegal: result is 0, out_err = 1, out_zero = 1.
- All operations are pure bitwise per bit i, with no carry and no width change.
- Stage 1 register (s1): captures in_op, in_a and in_b when in_valid && in_ready.
- Stage 2 register (output): captures f(s1_op, s1_a, s1_b) and its flags when s1_valid && s2_adv.
- Advance rules:
  - s2_adv = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_adv, as a combinational path from out_ready.
- Valid updates:
  - s1_valid next state: if in_valid && in_ready then 1; else if s2_adv then 0; else hold.
  - out_valid next state: if s2_adv then s1_valid; else hold.
- Latency: a request accepted at edge k appears with out_valid = 1 after edge k+1, i.e. 2 register stages. Throughput is 1 per cycle with out_ready held high.
- Backpressure: when out_ready is low with out_valid high, the output registers hold stable. Stage 1 can absorb exactly one more request, then in_ready falls.
- No request is lost or duplicated. Every output is registered; no combinational path exists from in_* to out_*.
- Simultaneous events in one cycle are legal: accept into s1, move s1 to the output register, and hand off the output.
- done_cnt increments by 1 on each out_valid && out_ready cycle. It wraps from 2^CNT_W-1 to 0 with no saturation.
- Flags are computed from the stage-2 result. They are meaningful only while out_valid = 1.

Test Plan:
- Reset then single OR: a=0xCA981547, b=0x3567EAB9, op=001 -> two edges later out_valid=1, out_result=0xFFFFFFFF, out_neg=1, out_zero=0, out_err=0; after handoff done_cnt=1.
- XOR and AND back-to-back with out_ready=1:
  - XOR with a=0x3567EAB8, b=0x3567EAB9 -> 0x00000001.
  - AND with the same operands on the next cycle -> 0x3567EAB8 one cycle after the XOR result.
  - Both have zero=0 and neg=0.
- Backpressure: issue 3 requests with out_ready=0 -> first result holds stable and in_ready drops after the second acceptance. The third request waits. Raising out_ready drains all 3 in order with no loss; done_cnt=3.
- Illegal opcode 111 with any operands -> out_result=0, out_zero=1, out_err=1. A following NOT A of 0xFFFFFFFF gives 0x00000000, zero=1, err=0.
- Async reset asserted while s1 and the output register are both valid -> out_valid, done_cnt and flags are 0 immediately without a clock edge. After release, in_ready=1 and no stale result is emitted.
- Counter wrap with CNT_W=2: 5 handoffs -> done_cnt sequence 1,2,3,0,1.
